// File: rtl/sa_ws_feeder.sv
// Input sequencer for a weight-stationary systolic array: loads ARR_HEIGHT weight rows,
// then streams num_vecs activation vectors, then flushes for the drain length.
// Latency: every output is registered; weights and activation row 0 appear 1 cycle after
// transfer, and activation row r appears after r+1 cycles when skew is enabled.
// Backpressure: w_ready/a_ready depend on state only; an upstream stall makes the array hold
// (LOAD) or inserts a zero bubble (COMPUTE).
//
// Build option: define SA_FEEDER_SKEW_EN for diagonal activation skew (drain ARR_HEIGHT+ARR_WIDTH-1).
// Without it, all activation words are delayed by one cycle and the drain is ARR_WIDTH cycles.
//
// Ports: clk/reset (async active-high); start, num_vecs: tile request; w_valid/w_ready/w_data:
// weight rows; a_valid/a_ready/a_data: activation vectors; control, w_in_vec, a_in_vec: array
// drive (00 hold, 01 weight load, 10 compute); busy: tile in progress; done: completion pulse.
module sa_ws_feeder #(
    parameter int ARR_WIDTH  = 4,
    parameter int ARR_HEIGHT = 4,
    parameter int WORD_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [CNT_WIDTH-1:0]             num_vecs,
    input  logic                             w_valid,
    output logic                             w_ready,
    input  logic [WORD_WIDTH*ARR_WIDTH-1:0]  w_data,
    input  logic                             a_valid,
    output logic                             a_ready,
    input  logic [WORD_WIDTH*ARR_HEIGHT-1:0] a_data,
    output logic [1:0]                       control,
    output logic [WORD_WIDTH*ARR_WIDTH-1:0]  w_in_vec,
    output logic [WORD_WIDTH*ARR_HEIGHT-1:0] a_in_vec,
    output logic                             busy,
    output logic                             done
);

`ifdef SA_FEEDER_SKEW_EN
    localparam int DRAIN_LEN = ARR_HEIGHT + ARR_WIDTH - 1;
`else
    localparam int DRAIN_LEN = ARR_WIDTH;
`endif
    localparam int WCW = $clog2(ARR_HEIGHT + 1);
    localparam int DCW = $clog2(DRAIN_LEN + 1);

    localparam logic [1:0] CTL_HOLD = 2'b00;
    localparam logic [1:0] CTL_LOAD = 2'b01;
    localparam logic [1:0] CTL_COMP = 2'b10;

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

    state_t                          state_q, state_d;
    logic [CNT_WIDTH-1:0]            num_q;
    logic [CNT_WIDTH-1:0]            v_cnt;
    logic [WCW-1:0]                  w_cnt;
    logic [DCW-1:0]                  d_cnt;
    logic                            w_xfer, a_xfer;
    logic                            last_w, last_v, last_d;
    logic [1:0]                      control_d;
    logic [WORD_WIDTH*ARR_WIDTH-1:0] w_in_d;
    logic [WORD_WIDTH*ARR_HEIGHT-1:0] a_push;
    logic                            done_d;

    assign w_ready = (state_q == LOAD);
    assign a_ready = (state_q == COMPUTE);
    assign busy    = (state_q != IDLE);
    assign w_xfer  = w_valid && w_ready;
    assign a_xfer  = a_valid && a_ready;
    assign last_w  = (w_cnt == WCW'(ARR_HEIGHT - 1));
    assign last_v  = ((v_cnt + CNT_WIDTH'(1)) == num_q);
    assign last_d  = (d_cnt == DCW'(DRAIN_LEN - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    if (w_xfer && last_w) state_d = (num_q == '0) ? IDLE : COMPUTE;
            COMPUTE: if (a_xfer && last_v) state_d = DRAIN;
            DRAIN:   if (last_d) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: values presented to the array on the next cycle
    always_comb begin
        control_d = CTL_HOLD;
        w_in_d    = w_in_vec;
        a_push    = '0;
        done_d    = 1'b0;
        case (state_q)
            LOAD: begin
                if (w_xfer) begin
                    control_d = CTL_LOAD;
                    w_in_d    = w_data;
                end
                // Zero-length tile completes straight out of LOAD
                done_d = w_xfer && last_w && (num_q == '0);
            end
            COMPUTE: begin
                control_d = CTL_COMP;
                if (a_xfer) a_push = a_data;
            end
            DRAIN: begin
                control_d = CTL_COMP;
                done_d    = last_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            control  <= CTL_HOLD;
            w_in_vec <= '0;
            done     <= 1'b0;
        end else begin
            control  <= control_d;
            w_in_vec <= w_in_d;
            done     <= done_d;
        end
    end

    // Tile counters; cleared when a tile is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_q <= '0;
            v_cnt <= '0;
            w_cnt <= '0;
            d_cnt <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        num_q <= num_vecs;
                        v_cnt <= '0;
                        w_cnt <= '0;
                        d_cnt <= '0;
                    end
                end
                LOAD:    if (w_xfer) w_cnt <= w_cnt + WCW'(1);
                COMPUTE: if (a_xfer) v_cnt <= v_cnt + CNT_WIDTH'(1);
                DRAIN:   d_cnt <= d_cnt + DCW'(1);
                default: ;
            endcase
        end
    end

`ifdef SA_FEEDER_SKEW_EN
    // Row r passes through r+1 registers so that it enters the array r cycles after row 0
    for (genvar r = 0; r < ARR_HEIGHT; r++) begin : g_skew
        logic [WORD_WIDTH-1:0] stage_q [0:r];
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int k = 0; k <= r; k++) stage_q[k] <= '0;
            end else begin
                stage_q[0] <= a_push[r*WORD_WIDTH +: WORD_WIDTH];
                for (int k = 1; k <= r; k++) stage_q[k] <= stage_q[k-1];
            end
        end
        assign a_in_vec[r*WORD_WIDTH +: WORD_WIDTH] = stage_q[r];
    end
`else
    logic [WORD_WIDTH*ARR_HEIGHT-1:0] a_vec_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_vec_q <= '0;
        end else begin
            a_vec_q <= a_push;
        end
    end
    assign a_in_vec = a_vec_q;
`endif

endmodule
